// File: rtl/result_word_packer.sv
// Packs four 8-bit result pixels (first byte in [31:24]) into a 32-bit word and writes it to result memory.
// Words go out over a mem_wr/mem_ack handshake at auto-incrementing addresses; flush emits a zero-padded partial word.
module result_word_packer #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              flush,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] word_count
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [31:0]       pack_q, pack_d;
  logic [31:0]       hold_q, hold_d;
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic              accept;
  logic              wr_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (flush) state_d = FLUSH;
      FLUSH:   if (cnt_q == 2'd0 && !out_valid_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // in_ready depends only on registered state, so a 4th byte waits one cycle after an ack frees the holder.
  always_comb begin
    in_ready = (state_q == RUN) && !(cnt_q == 2'd3 && out_valid_q);
    busy     = (state_q != IDLE);
    done     = (state_q == DONE);
  end

  assign accept     = in_valid && in_ready;
  assign wr_ack     = out_valid_q && mem_ack;
  assign mem_wr     = out_valid_q;
  assign mem_addr   = addr_q;
  assign mem_data   = hold_q;
  assign word_count = wcnt_q;

  always_comb begin
    cnt_d       = cnt_q;
    pack_d      = pack_q;
    hold_d      = hold_q;
    out_valid_d = out_valid_q;
    addr_d      = addr_q;
    wcnt_d      = wcnt_q;

    if (wr_ack) begin
      out_valid_d = 1'b0;
      addr_d      = addr_q + ADDR_W'(1);
      wcnt_d      = wcnt_q + ADDR_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d = base_addr;
          wcnt_d = '0;
          cnt_d  = 2'd0;
          pack_d = '0;
        end
      end
      RUN: begin
        if (accept) begin
          if (cnt_q == 2'd3) begin
            hold_d      = {pack_q[31:8], in_data};
            out_valid_d = 1'b1;
            cnt_d       = 2'd0;
            pack_d      = '0;
          end else begin
            case (cnt_q)
              2'd0:    pack_d[31:24] = in_data;
              2'd1:    pack_d[23:16] = in_data;
              default: pack_d[15:8]  = in_data;
            endcase
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      FLUSH: begin
        // Unfilled low bytes of pack_q are already zero from the last clear.
        if (cnt_q != 2'd0 && !out_valid_q) begin
          hold_d      = pack_q;
          out_valid_d = 1'b1;
          cnt_d       = 2'd0;
          pack_d      = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= 2'd0;
      pack_q      <= '0;
      hold_q      <= '0;
      out_valid_q <= 1'b0;
      addr_q      <= '0;
      wcnt_q      <= '0;
    end else begin
      cnt_q       <= cnt_d;
      pack_q      <= pack_d;
      hold_q      <= hold_d;
      out_valid_q <= out_valid_d;
      addr_q      <= addr_d;
      wcnt_q      <= wcnt_d;
    end
  end

endmodule
